// File: rtl/game_pkg.sv
// Shared constants for the higher/lower game: result codes, seven-segment glyphs
// ({g,f,e,d,c,b,a}, active high) and the display FSM state encoding.
package game_pkg;

   localparam logic [3:0] CODE_CORRECT = 4'd10;
   localparam logic [3:0] CODE_WRONG   = 4'd11;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_C     = 7'h39;
   localparam logic [6:0] GLYPH_F     = 7'h71;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam logic [1:0] StShow     = 2'd0;
   localparam logic [1:0] StBlinkOn  = 2'd1;
   localparam logic [1:0] StBlinkOff = 2'd2;
   localparam logic [1:0] StBlank    = 2'd3;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational lookup from a 4-bit game code to its seven-segment glyph.
module seg7_glyph
   import game_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] glyph_o
);

   always_comb begin
      glyph_o = GLYPH_BLANK;
      case (code_i)
         4'd0:         glyph_o = GLYPH_0;
         4'd1:         glyph_o = GLYPH_1;
         4'd2:         glyph_o = GLYPH_2;
         4'd3:         glyph_o = GLYPH_3;
         4'd4:         glyph_o = GLYPH_4;
         4'd5:         glyph_o = GLYPH_5;
         4'd6:         glyph_o = GLYPH_6;
         4'd7:         glyph_o = GLYPH_7;
         4'd8:         glyph_o = GLYPH_8;
         4'd9:         glyph_o = GLYPH_9;
         CODE_CORRECT: glyph_o = GLYPH_C;
         CODE_WRONG:   glyph_o = GLYPH_F;
         default:      glyph_o = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/result_display_driver.sv
// Drives one seven-segment digit from the game code: steady digits, blinking
// result glyphs, and a decimal point that marks a hot win streak.
module result_display_driver
   import game_pkg::*;
#(
   parameter int unsigned BLINK_HALF = 2_500_000,
   parameter int unsigned CNT_LEN    = 22,
   parameter int unsigned STREAK_HOT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] value,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] streak
);

   logic [3:0]         value_q;
   logic [1:0]         state_q, state_d;
   logic [CNT_LEN-1:0] cnt_q, cnt_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;
   logic [3:0]         streak_q, streak_d;
   logic [6:0]         glyph;
   logic               enter_ok, enter_bad, half_done;

   seg7_glyph u_glyph (
      .code_i  (value),
      .glyph_o (glyph)
   );

   assign enter_ok  = (value == CODE_CORRECT) && (value_q != CODE_CORRECT);
   assign enter_bad = (value == CODE_WRONG) && (value_q != CODE_WRONG);
   assign half_done = (cnt_q == CNT_LEN'(BLINK_HALF - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (enter_ok || enter_bad) begin
         state_d = StBlinkOn;
      end else if (value <= 4'd9) begin
         state_d = StShow;
      end else if (value >= 4'd12) begin
         state_d = StBlank;
      end else begin
         // Result code held: keep toggling the blink phase.
         case (state_q)
            StBlinkOn: begin
               if (half_done) state_d = StBlinkOff;
               else           cnt_d   = cnt_q + 1'b1;
            end
            StBlinkOff: begin
               if (half_done) state_d = StBlinkOn;
               else           cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      seg_d = ((state_d == StShow) || (state_d == StBlinkOn)) ? glyph : GLYPH_BLANK;
   end

   always_comb begin
      streak_d = streak_q;
      if (enter_ok) begin
         streak_d = (streak_q >= 4'd9) ? 4'd9 : streak_q + 4'd1;
      end else if (enter_bad) begin
         streak_d = 4'd0;
      end
      dp_d = (streak_d >= 4'(STREAK_HOT));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         value_q  <= 4'd0;
         state_q  <= StShow;
         cnt_q    <= '0;
         seg_q    <= GLYPH_BLANK;
         dp_q     <= 1'b0;
         streak_q <= 4'd0;
      end else begin
         value_q  <= value;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         streak_q <= streak_d;
      end
   end

   assign seg    = seg_q;
   assign dp     = dp_q;
   assign streak = streak_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed vector bench for result_display_driver with BLINK_HALF=4, STREAK_HOT=3.
module tb_result_display_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] value;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] streak;

   int n_checks = 0;
   int n_errors = 0;

   result_display_driver #(
      .BLINK_HALF (4),
      .CNT_LEN    (3),
      .STREAK_HOT (3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .value  (value),
      .seg    (seg),
      .dp     (dp),
      .streak (streak)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] val;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic [3:0] exp_streak;
   } vec_t;

   vec_t vecs[$];

   logic [6:0] glyphs [16];

   task automatic add(input logic r, input logic [3:0] v, input logic [6:0] s,
                      input logic d, input logic [3:0] k);
      vec_t t;
      t.rst_n = r; t.val = v; t.exp_seg = s; t.exp_dp = d; t.exp_streak = k;
      vecs.push_back(t);
   endtask

   // Hold a result code after entry: n rows of expected blink pattern, phase
   // position given by the count of cycles already spent since entry.
   task automatic add_blink(input logic [3:0] v, input int since, input int n,
                            input logic d, input logic [3:0] k);
      for (int i = 0; i < n; i++) begin
         add(1'b1, v, (((since + i) / 4) % 2 == 0) ? glyphs[v] : 7'h00, d, k);
      end
   endtask

   initial begin
      glyphs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h39, 7'h71, 7'h00, 7'h00, 7'h00, 7'h00};

      // Reset with 7 present, then release.
      add(1'b0, 4'd7, 7'h00, 1'b0, 4'd0);
      add(1'b0, 4'd7, 7'h00, 1'b0, 4'd0);
      add(1'b1, 4'd7, 7'h07, 1'b0, 4'd0);
      // Digit sweep then blank code.
      for (int i = 0; i < 10; i++) add(1'b1, 4'(i), glyphs[i], 1'b0, 4'd0);
      add(1'b1, 4'd12, 7'h00, 1'b0, 4'd0);
      add(1'b1, 4'd15, 7'h00, 1'b0, 4'd0);
      // Correct held 16 cycles: counts once.
      add_blink(4'd10, 0, 16, 1'b0, 4'd1);
      // Streak build-up, then a wrong entry.
      add(1'b1, 4'd5,  7'h6D, 1'b0, 4'd1);
      add(1'b1, 4'd10, 7'h39, 1'b0, 4'd2);
      add(1'b1, 4'd5,  7'h6D, 1'b0, 4'd2);
      add(1'b1, 4'd10, 7'h39, 1'b1, 4'd3);
      add_blink(4'd11, 0, 8, 1'b0, 4'd0);
      // Ten correct entries saturate at 9; then 10 -> 11 directly.
      for (int i = 1; i <= 10; i++) begin
         add(1'b1, 4'd10, 7'h39, (i >= 3), (i > 9) ? 4'd9 : 4'(i));
         if (i < 10) add(1'b1, 4'd5, 7'h6D, (i >= 3), 4'(i));
      end
      add_blink(4'd11, 0, 6, 1'b0, 4'd0);
      // Now in BLINK_OFF with 11: reset, then release with 11 still present.
      add(1'b0, 4'd11, 7'h00, 1'b0, 4'd0);
      add_blink(4'd11, 0, 5, 1'b0, 4'd0);
      // Reset must clear a hot streak; release with 10 re-enters.
      add(1'b1, 4'd5,  7'h6D, 1'b0, 4'd0);
      add(1'b1, 4'd10, 7'h39, 1'b0, 4'd1);
      add(1'b1, 4'd5,  7'h6D, 1'b0, 4'd1);
      add(1'b1, 4'd10, 7'h39, 1'b0, 4'd2);
      add(1'b1, 4'd5,  7'h6D, 1'b0, 4'd2);
      add(1'b1, 4'd10, 7'h39, 1'b1, 4'd3);
      add(1'b1, 4'd10, 7'h39, 1'b1, 4'd3);
      add(1'b0, 4'd10, 7'h00, 1'b0, 4'd0);
      add(1'b1, 4'd10, 7'h39, 1'b0, 4'd1);
      add(1'b1, 4'd10, 7'h39, 1'b0, 4'd1);

      reset = 1'b0;
      value = 4'd7;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset = vecs[i].rst_n;
         value = vecs[i].val;
         @(posedge clk);
         #1;
         n_checks++;
         if (seg !== vecs[i].exp_seg) begin
            n_errors++;
            $display("FAIL seg vec %0d: got %h expected %h", i, seg, vecs[i].exp_seg);
         end
         n_checks++;
         if (dp !== vecs[i].exp_dp) begin
            n_errors++;
            $display("FAIL dp vec %0d: got %b expected %b", i, dp, vecs[i].exp_dp);
         end
         n_checks++;
         if (streak !== vecs[i].exp_streak) begin
            n_errors++;
            $display("FAIL streak vec %0d: got %0d expected %0d", i, streak,
                     vecs[i].exp_streak);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/result_display_driver.md
# result_display_driver

Consumes the 4-bit `value` code produced by the higher/lower game core and drives a single common-cathode seven-segment digit plus decimal point. Codes 0–9 show a steady digit. Code 10 (correct) and code 11 (wrong) show a blinking result glyph. A registered win-streak counter lights the decimal point once the player has three or more consecutive correct guesses. It sits between the game core and the board's segment pins.

## Interface
- `BLINK_HALF`, default 2_500_000: cycles per blink half-period. Legal range ≥ 2.
- `CNT_LEN`, default 22: blink counter width. Must satisfy 2^CNT_LEN > BLINK_HALF.
- `STREAK_HOT`, default 3: streak value at or above which `dp` lights.
- `clk`, input, 1: single clock; everything is registered on its rising edge.
- `reset`, input, 1: synchronous, active-low (0 resets on the next rising edge).
- `value`, input, 4: game code. 0–9 are digits, 10 is correct, 11 is wrong, 12–15 are unused.
- `seg`, output, 7: {g,f,e,d,c,b,a}, active high, registered.
- `dp`, output, 1: hot-streak indicator, registered.
- `streak`, output, 4: consecutive-correct count, 0–9, registered.

## Operation
- `value_q` register holds the previous cycle's `value`. Events are combinational on `value`/`value_q`:
  - ENTER_OK = (`value`==10) && (`value_q`!=10)
  - ENTER_BAD = (`value`==11) && (`value_q`!=11)
- Glyphs:
  - digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex)
  - 10: 39 ('C')
  - 11: 71 ('F')
  - 12–15: 00 (blank)
- FSM states: SHOW, BLINK_ON, BLINK_OFF, BLANK.
  - Any state goes to BLINK_ON on ENTER_OK or ENTER_BAD; the blink counter clears to 0.
  - Any state goes to SHOW when `value` is 0–9, and to BLANK when `value` is 12–15; the counter clears in both cases.
  - BLINK_ON goes to BLINK_OFF when counter == BLINK_HALF−1 (counter clears). Otherwise the counter increments.
  - BLINK_OFF goes back to BLINK_ON under the same rule.
  - In BLINK_ON/BLINK_OFF with `value` unchanged and still 10/11, the blink continues.
- Next `seg`:
  - glyph(`value`) in SHOW and BLINK_ON
  - 00 in BLINK_OFF and BLANK
  - computed from the next state, so a new code appears one cycle after it is sampled.
- Streak:
  - ENTER_OK increments `streak`, saturating at 9.
  - ENTER_BAD clears it to 0.
  - Digits and blank codes leave it unchanged.
  - Next `dp` = (next `streak` ≥ STREAK_HOT).
- A direct 10→11 transition is an ENTER_BAD. The blink restarts in phase ON and the streak clears.
- A direct 11→10 transition is an ENTER_OK.

## Timing
- Reset (`reset`=0 at an edge): state SHOW, `value_q`=0, counter=0, `seg`=00, `dp`=0, `streak`=0. This applies mid-blink too, and reset has priority over all events.
- After reset releases, the first rising edge samples `value`, and `seg` shows its glyph (latency 1 cycle).
- Result entry: `value` becomes 10 before edge k, so `seg`=39 after edge k.
  - `seg` stays 39 through edge k+BLINK_HALF−1.
  - `seg`=00 after edge k+BLINK_HALF.
  - `seg`=39 again after edge k+2·BLINK_HALF.
- `streak` and `dp` update on the same edge as the entering glyph.
- Holding 10 for many cycles counts once. A digit followed by 10 again counts again.

## Structure
- Shared package `game_pkg`:
  - CODE_CORRECT=4'd10, CODE_WRONG=4'd11
  - seven-segment glyph constants
  - FSM state encoding (2-bit)
- Sub-module `seg7_glyph`: purely combinational 4-bit code to 7-bit glyph lookup. It is instantiated once, and the driver registers its output.

## Test plan
Bench uses BLINK_HALF=4, STREAK_HOT=3.
- Reset with `value`=7, then release → `seg`=00 during reset; `seg`=07 one edge after release; `dp`=0, `streak`=0.
- Sweep `value` 0..9, then 12 → `seg` follows 3F…6F with 1-cycle latency; 12 gives 00.
- `value`=10 held 16 cycles → `seg` 39 ×4, 00 ×4, 39 ×4, 00 ×4; `streak`=1 after the entry edge only.
- Sequence 10,5,10,5,10 → `streak` 1,2,3; `dp` rises with the third entry. Then 11 → `streak`=0, `dp`=0, `seg`=71 blinking.
- Ten correct entries → `streak` saturates at 9. Then 10→11 directly → restart in phase ON, `seg`=71, `streak`=0.
- `reset`=0 during BLINK_OFF with `value`=11 → all outputs 0 after the edge. On release with `value`=11 still present → `seg`=71 in phase ON and `streak` stays 0.
